serial_deser: RTL

//  Serial-to-parallel receiver; the input-side counterpart of the matrix driver's load/shift serializer.

---
 rtl/serial_deser_pkg.sv | 17 +
 rtl/serial_deser_rise_det.sv | 18 +
 rtl/serial_deser.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_deser_pkg.sv
// Shared types and helpers for the serial_deser receiver.
// The PAR state is only reachable when SERIAL_DESER_PARITY_EN is defined.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Returns 1 when the vector has an odd number of ones (even-parity violation)
  function automatic logic odd_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_deser_rise_det.sv
// Rising-edge detector for the serial strobe: one stb per low-to-high transition of en.
module serial_deser_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic stb
);

  logic en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) en_q <= 1'b0;
    else       en_q <= en;
  end

  assign stb = en & ~en_q;

endmodule

// File: rtl/serial_deser.sv
// serial_deser: framed MSB-first serial receiver with a valid/ready holding register.
// Define SERIAL_DESER_PARITY_EN to add a trailing even-parity bit per word and drive perr.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int N    = 14,
  parameter int CNTW = $clog2(N + 2)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame,
  input  logic         en,
  input  logic         sdi,
  input  logic         ready,
  output logic [N-1:0] q,
  output logic         valid,
  output logic         ovf,
  output logic         short_frm,
  output logic         perr
);

  state_t          state, state_n;
  logic [N-1:0]    sr;
  logic [CNTW-1:0] cnt;
  logic [N-1:0]    word;
  logic            stb;
  logic            shift_en;
  logic            complete;
  logic            clear;
  logic            short_n;

  serial_deser_rise_det u_rise (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .stb   (stb)
  );

`ifdef SERIAL_DESER_PARITY_EN
  assign word = sr;
`else
  assign word = {sr[N-2:0], sdi};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // frame low overrides everything, including a final strobe on the same edge
  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    complete = 1'b0;
    clear    = 1'b0;
    short_n  = 1'b0;
    if (!frame) begin
      state_n = IDLE;
      clear   = 1'b1;
      short_n = ((state == SHIFT) && (cnt != '0)) || (state == PAR);
    end else begin
      case (state)
        IDLE:  state_n = SHIFT;
        SHIFT: begin
          if (stb) begin
            shift_en = 1'b1;
            if (cnt == CNTW'(N - 1)) begin
`ifdef SERIAL_DESER_PARITY_EN
              state_n = PAR;
`else
              complete = 1'b1;
              state_n  = HOLD;
`endif
            end
          end
        end
        PAR: begin
          if (stb) begin
            complete = 1'b1;
            state_n  = HOLD;
          end
        end
        HOLD:    state_n = HOLD;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      cnt       <= '0;
      q         <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      short_frm <= 1'b0;
    end else begin
      if (clear) begin
        sr  <= '0;
        cnt <= '0;
      end else if (shift_en) begin
        sr  <= {sr[N-2:0], sdi};
        cnt <= cnt + CNTW'(1);
      end
      // A completing word always wins over a same-edge consume
      if (complete) begin
        q     <= word;
        valid <= 1'b1;
        if (valid && !ready) ovf <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      short_frm <= short_n;
    end
  end

`ifdef SERIAL_DESER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         perr <= 1'b0;
    else if (complete) perr <= odd_parity(64'({sr, sdi}));
  end
`else
  assign perr = 1'b0;
`endif

endmodule
